// File: rtl/serial_load_if.sv
// Bundle between the serial load sequencer and its environment: loader pins,
// shift register hookup and the word valid/ready handshake.
interface serial_load_if #(
    parameter int WORD_W = 16
);

    logic              start_i;
    logic              abort_i;
    logic              bit_stb_i;
    logic              sdata_i;
    logic              sr_en_o;
    logic              sr_in_o;
    logic [WORD_W-1:0] sr_q_i;
    logic [WORD_W-1:0] word_o;
    logic              valid_o;
    logic              ready_i;
    logic              busy_o;
    logic              overrun_o;
    logic              clr_ovr_i;
    logic              par_err_o;

    // slave is the sequencer itself; master is the loader/register/consumer side
    modport slave (
        input  start_i, abort_i, bit_stb_i, sdata_i, sr_q_i, ready_i, clr_ovr_i,
        output sr_en_o, sr_in_o, word_o, valid_o, busy_o, overrun_o, par_err_o
    );

    modport master (
        output start_i, abort_i, bit_stb_i, sdata_i, sr_q_i, ready_i, clr_ovr_i,
        input  sr_en_o, sr_in_o, word_o, valid_o, busy_o, overrun_o, par_err_o
    );

endinterface

// File: rtl/serial_load_ctrl.sv
// Frames a serial MSB-first bitstream into WORD_W-bit words via an external SIPO
// register and hands words out over valid/ready. Define SERIAL_LOAD_PARITY_EN for even parity.
module serial_load_ctrl #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic         clk,
    input  logic         resetb,
    serial_load_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PARITY  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] word_q;
    logic              valid_q;
    logic              busy_q;
    logic              overrun_q;
    logic              accept;
    logic              can_load;

    assign accept   = valid_q && bus.ready_i;
    assign can_load = !valid_q || accept;

    // Shift enable stays combinational so the register sees the strobe in the same cycle.
    assign bus.sr_en_o   = (state == SHIFT) && bus.bit_stb_i;
    assign bus.sr_in_o   = bus.sdata_i;
    assign bus.word_o    = word_q;
    assign bus.valid_o   = valid_q;
    assign bus.busy_o    = busy_q;
    assign bus.overrun_o = overrun_q;

`ifdef SERIAL_LOAD_PARITY_EN
    logic par_err_q;
    assign bus.par_err_o = par_err_q;
`else
    assign bus.par_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            count     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SERIAL_LOAD_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
`ifdef SERIAL_LOAD_PARITY_EN
            par_err_q <= 1'b0;
`endif
            // Later assignments below override these when a capture lands in the same cycle.
            if (accept) begin
                valid_q <= 1'b0;
            end
            if (bus.clr_ovr_i) begin
                overrun_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state  <= SHIFT;
                        count  <= '0;
                        busy_q <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (bus.abort_i) begin
                        state  <= IDLE;
                        count  <= '0;
                        busy_q <= 1'b0;
                    end else if (bus.bit_stb_i) begin
                        if (count == LAST_BIT) begin
                            count <= '0;
`ifdef SERIAL_LOAD_PARITY_EN
                            state <= PARITY;
`else
                            state <= CAPTURE;
`endif
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end

`ifdef SERIAL_LOAD_PARITY_EN
                PARITY: begin
                    if (bus.abort_i) begin
                        state  <= IDLE;
                        count  <= '0;
                        busy_q <= 1'b0;
                    end else if (bus.bit_stb_i) begin
                        // Even parity: data ones plus the parity bit must sum to even.
                        if ((^bus.sr_q_i) == bus.sdata_i) begin
                            state <= CAPTURE;
                        end else begin
                            state     <= IDLE;
                            busy_q    <= 1'b0;
                            par_err_q <= 1'b1;
                        end
                    end
                end
`endif

                CAPTURE: begin
                    state  <= IDLE;
                    count  <= '0;
                    busy_q <= 1'b0;
                    if (!bus.abort_i) begin
                        if (can_load) begin
                            word_q  <= bus.sr_q_i;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    count  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
